// File: rtl/core_reg_operand_fetch.sv
// Operand-fetch sequencer: maps rn/rm/rs to banked physical indices and reads them through
// the register file's single read port one per cycle. The bundle is held for decode/execute.
module core_reg_operand_fetch #(
  parameter logic [31:0] PC_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mode,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rm,
  input  logic [3:0]  in_rs,
  input  logic [2:0]  in_use,
  input  logic [31:0] pc_value,
  output logic [4:0]  rd_index,
  input  logic [31:0] rd_value,
  input  logic        wb_enable,
  input  logic [4:0]  wb_index,
  input  logic [31:0] wb_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rn,
  output logic [31:0] out_rm,
  output logic [31:0] out_rs
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  function automatic logic [4:0] map_reg(input logic [4:0] mode, input logic [3:0] r);
    logic [4:0] idx;
    idx = {1'b0, r};
    case (mode)
      5'h11: if (r >= 4'd8 && r <= 4'd14) idx = {1'b0, r} + 5'd7;
      5'h12: if (r == 4'd13 || r == 4'd14) idx = {1'b0, r} + 5'd9;
      5'h13: if (r == 4'd13 || r == 4'd14) idx = {1'b0, r} + 5'd11;
      5'h17: if (r == 4'd13 || r == 4'd14) idx = {1'b0, r} + 5'd13;
      5'h1B: if (r == 4'd13 || r == 4'd14) idx = {1'b0, r} + 5'd15;
      default: idx = {1'b0, r};
    endcase
    return idx;
  endfunction

  state_t      state, state_next;
  logic [4:0]  phys [3];
  logic [31:0] operand [3];
  logic [2:0]  pending;
  logic [2:0]  issued;
  logic        cap_valid;
  logic [1:0]  cap_slot;
  logic [4:0]  rd_index_q;

  logic [3:0]  src [3];
  logic [2:0]  reads;
  logic [1:0]  next_slot;
  logic [2:0]  remaining;
  logic        accept;

  assign src[0] = in_rn;
  assign src[1] = in_rm;
  assign src[2] = in_rs;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_reads
      assign reads[gi] = in_use[gi] && (src[gi] != 4'd15);
    end
  endgenerate

  assign accept = in_valid && (state == IDLE);

  always_comb begin
    next_slot = 2'd2;
    if (pending[0])      next_slot = 2'd0;
    else if (pending[1]) next_slot = 2'd1;
    remaining = pending;
    remaining[next_slot] = 1'b0;
  end

  // A request with no file reads still spends one cycle in DRAIN so that
  // out_valid always rises N+1 edges after the accept edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (reads != 3'b000) ? ISSUE : DRAIN;
      ISSUE: if (remaining == 3'b000) state_next = DRAIN;
      DRAIN: state_next = HOLD;
      HOLD:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 3'b000;
      issued     <= 3'b000;
      cap_valid  <= 1'b0;
      cap_slot   <= 2'd0;
      rd_index_q <= 5'd0;
      for (int i = 0; i < 3; i++) begin
        phys[i]    <= 5'd0;
        operand[i] <= 32'd0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          pending   <= reads;
          issued    <= 3'b000;
          cap_valid <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            phys[i]    <= map_reg(in_mode, src[i]);
            operand[i] <= (in_use[i] && src[i] == 4'd15) ? pc_value + PC_OFFSET : 32'd0;
          end
        end
        ISSUE: begin
          rd_index_q         <= phys[next_slot];
          pending            <= remaining;
          issued[next_slot]  <= 1'b1;
          cap_valid          <= 1'b1;
          cap_slot           <= next_slot;
        end
        DRAIN: cap_valid <= 1'b0;
        default: ;
      endcase

      if (cap_valid && (state == ISSUE || state == DRAIN))
        operand[cap_slot] <= rd_value;

      // Later assignment wins: a writeback beats a same-edge read capture.
      if (state != IDLE) begin
        for (int i = 0; i < 3; i++)
          if (issued[i] && wb_enable && wb_index == phys[i])
            operand[i] <= wb_value;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign rd_index  = rd_index_q;
  assign out_rn    = operand[0];
  assign out_rm    = operand[1];
  assign out_rs    = operand[2];

endmodule

// File: tb/tb_core_reg_operand_fetch.sv
// Bench for core_reg_operand_fetch: bench-side register file, behavioural model of the
// operand bundle (always equal to the file's current contents), directed and random requests.
module tb_core_reg_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_mode;
  logic [3:0]  in_rn, in_rm, in_rs;
  logic [2:0]  in_use;
  logic [31:0] pc_value;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic        wb_enable;
  logic [4:0]  wb_index;
  logic [31:0] wb_value;
  logic        out_valid, out_ready;
  logic [31:0] out_rn, out_rm, out_rs;

  always #5 clk = ~clk;

  core_reg_operand_fetch #(.PC_OFFSET(32'd8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs), .in_use(in_use),
    .pc_value(pc_value), .rd_index(rd_index), .rd_value(rd_value),
    .wb_enable(wb_enable), .wb_index(wb_index), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rn(out_rn), .out_rm(out_rm), .out_rs(out_rs)
  );

  // Register file model: writes on the edge, read data follows rd_index.
  logic [31:0] mem [0:29];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 30; i++) mem[i] <= 32'hA5000000 + i;
    end else if (wb_enable && wb_index < 5'd30) begin
      mem[wb_index] <= wb_value;
    end
  end
  assign rd_value = (rd_index < 5'd30) ? mem[rd_index] : 32'h0;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model of the request in flight
  bit          chk_en = 1'b0;
  bit          busy = 1'b0;
  int          tm;
  int          m_n;
  logic [4:0]  m_list [3];
  logic [3:0]  m_reg [3];
  logic [4:0]  m_phys [3];
  logic [2:0]  m_use;
  logic [31:0] m_pc;
  logic [31:0] cap [3];

  function automatic logic [4:0] phys(input logic [4:0] mode, input logic [3:0] r);
    int base;
    case (mode)
      5'h12: base = 22;
      5'h13: base = 24;
      5'h17: base = 26;
      5'h1B: base = 28;
      default: base = -1;
    endcase
    if (mode == 5'h11 && r >= 8 && r <= 14) return 5'(int'(r) + 7);
    if (base >= 0 && (r == 13 || r == 14)) return 5'(base + int'(r) - 13);
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] exp_val(input int s);
    if (!m_use[s]) return 32'h0;
    if (m_reg[s] == 4'd15) return m_pc + 32'd8;
    return mem[m_phys[s]];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (!busy) begin
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        if (tm >= 1 && tm <= m_n) chk("rd_index_seq", {27'b0, rd_index}, {27'b0, m_list[tm-1]});
        else if (tm > m_n && m_n > 0) chk("rd_index_hold", {27'b0, rd_index}, {27'b0, m_list[m_n-1]});
        if (tm <= m_n) begin
          chk("out_valid_early", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("out_valid_hold", {31'b0, out_valid}, 32'd1);
          chk("out_rn", out_rn, exp_val(0));
          chk("out_rm", out_rm, exp_val(1));
          chk("out_rs", out_rs, exp_val(2));
        end
      end
    end
  end

  task automatic drive_wb(input int e, input int wb_edge, input logic [4:0] wi,
                          input logic [31:0] wv, input bit rnd);
    if (rnd) begin
      wb_enable = 1'($urandom % 2);
      wb_index  = ($urandom % 2 == 0) ? m_phys[$urandom % 3] : 5'($urandom_range(0, 29));
      wb_value  = $urandom;
    end else if (e == wb_edge) begin
      wb_enable = 1'b1; wb_index = wi; wb_value = wv;
    end else begin
      wb_enable = 1'b0;
    end
  endtask

  task automatic do_req(input logic [4:0] mode, input logic [3:0] rn, input logic [3:0] rm,
                        input logic [3:0] rs, input logic [2:0] use_f, input logic [31:0] pc,
                        input int hold, input int wb_edge, input logic [4:0] wi,
                        input logic [31:0] wv, input bit rnd);
    @(negedge clk);
    out_ready = 1'b0;
    m_reg[0] = rn; m_reg[1] = rm; m_reg[2] = rs;
    m_use = use_f; m_pc = pc; m_n = 0;
    for (int s = 0; s < 3; s++) begin
      m_phys[s] = phys(mode, m_reg[s]);
      if (use_f[s] && m_reg[s] != 4'd15) begin
        m_list[m_n] = m_phys[s];
        m_n++;
      end
    end
    in_mode = mode; in_rn = rn; in_rm = rm; in_rs = rs; in_use = use_f; pc_value = pc;
    in_valid = 1'b1;
    drive_wb(0, wb_edge, wi, wv, rnd);
    @(posedge clk);
    busy = 1'b1;
    tm = 0;
    for (int k = 0; k <= m_n + 1 + hold; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == m_n + 1) begin
        cap[0] = out_rn; cap[1] = out_rm; cap[2] = out_rs;
      end
      drive_wb(k + 1, wb_edge, wi, wv, rnd);
      out_ready = (k == m_n + 1 + hold);
      @(posedge clk);
      tm = k + 1;
    end
    busy = 1'b0;
    $display("req mode=%h rn=%0d rm=%0d rs=%0d use=%b pc=%h -> %h %h %h",
             mode, rn, rm, rs, use_f, pc, cap[0], cap[1], cap[2]);
  endtask

  task automatic file_write(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    wb_enable = 1'b1; wb_index = idx; wb_value = val;
    @(negedge clk);
    wb_enable = 1'b0;
  endtask

  logic [4:0] modes [9];

  initial begin
    modes[0] = 5'h10; modes[1] = 5'h11; modes[2] = 5'h12; modes[3] = 5'h13; modes[4] = 5'h17;
    modes[5] = 5'h1B; modes[6] = 5'h1F; modes[7] = 5'h00; modes[8] = 5'h05;
    rst = 1'b1; init_mem = 1'b1;
    in_valid = 1'b0; in_mode = 5'h10; in_rn = 0; in_rm = 0; in_rs = 0; in_use = 0;
    pc_value = 0; wb_enable = 1'b0; wb_index = 0; wb_value = 0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_rd_index", {27'b0, rd_index}, 32'd0);
    chk("reset_out_rn", out_rn, 32'd0);
    rst = 1'b0;

    file_write(5'd3, 32'h33);
    file_write(5'd4, 32'h44);
    file_write(5'd5, 32'h55);

    // Reset in the middle of ISSUE
    @(negedge clk);
    in_mode = 5'h10; in_rn = 4'd3; in_rm = 4'd15; in_rs = 4'd5; in_use = 3'b111;
    pc_value = 32'h100; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre_reset_rd_index", {27'b0, rd_index}, 32'd3);
    chk("pre_reset_out_rm", out_rm, 32'h108);
    #1 rst = 1'b1;
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_rd_index", {27'b0, rd_index}, 32'd0);
    chk("midreset_out_rm", out_rm, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    do_req(5'h10, 4'd3, 4'd4, 4'd5, 3'b111, 32'h0, 0, -1, 5'd0, 32'd0, 1'b0);
    chk("usr_rn", cap[0], 32'h33);
    chk("usr_rm", cap[1], 32'h44);
    chk("usr_rs", cap[2], 32'h55);
    chk("usr_last_idx", {27'b0, rd_index}, 32'd5);

    file_write(5'd24, 32'h2424);
    do_req(5'h13, 4'd13, 4'd15, 4'd0, 3'b011, 32'h1000, 1, -1, 5'd0, 32'd0, 1'b0);
    chk("svc_rn", cap[0], 32'h2424);
    chk("svc_rm_pc", cap[1], 32'h1008);
    chk("svc_rs_unused", cap[2], 32'h0);
    chk("svc_idx", {27'b0, rd_index}, 32'd24);

    file_write(5'd15, 32'h1111);
    do_req(5'h11, 4'd8, 4'd0, 4'd0, 3'b001, 32'h0, 0, 2, 5'd15, 32'hDEAD, 1'b0);
    chk("fiq_snoop_rn", cap[0], 32'hDEAD);
    chk("fiq_idx", {27'b0, rd_index}, 32'd15);

    do_req(5'h10, 4'd15, 4'd15, 4'd2, 3'b011, 32'hFFFF_FFFC, 5, -1, 5'd0, 32'd0, 1'b0);
    chk("r15_wrap_rn", cap[0], 32'h4);
    chk("r15_wrap_rm", cap[1], 32'h4);
    chk("r15_rs_unused", cap[2], 32'h0);

    file_write(5'd14, 32'h1414);
    do_req(5'h00, 4'd0, 4'd14, 4'd0, 3'b010, 32'h0, 0, -1, 5'd0, 32'd0, 1'b0);
    chk("badmode_idx", {27'b0, rd_index}, 32'd14);
    chk("badmode_rm", cap[1], 32'h1414);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] r [3];
      for (int s = 0; s < 3; s++)
        r[s] = ($urandom % 5 == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      do_req(modes[$urandom % 9], r[0], r[1], r[2], 3'($urandom), $urandom,
             int'($urandom_range(0, 3)), -1, 5'd0, 32'd0, 1'b1);
    end

    @(negedge clk);
    wb_enable = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
